// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: grants the bus to the I-cache or D-cache side,
// tracks outstanding reads and routes returning data back to the owner.
module mem_arbiter #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned OUT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_rdata,
    output logic        i_grant,
    output logic        d_grant,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic [15:0] rdata,
    output logic        err_spurious
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;
    typedef enum logic {OWN_I, OWN_D} side_t;

    if ((2 ** OUT_W) <= LATENCY) begin : g_cfg_check
        $error("mem_arbiter: OUT_W too narrow to count LATENCY outstanding reads");
    end

    state_t           state, state_nx;
    side_t            owner, owner_nx;
    side_t            last_owner, last_owner_nx;
    logic [OUT_W-1:0] cnt, cnt_nx;
    logic             err;
    logic             rd_fwd;
    logic             spurious;
    logic             overflow;
    logic             cnt_max;
    logic             own_active;

    // Forwarding: only the current owner, and only while it still requests.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_fwd    = 1'b0;
        case (state)
            GNT_I: begin
                if (i_req) begin
                    mem_en   = i_rd;
                    mem_addr = i_addr;
                    rd_fwd   = i_rd;
                end
            end
            GNT_D: begin
                if (d_req) begin
                    mem_en    = d_rd | d_wr;
                    mem_wr    = d_wr & ~d_rd;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    rd_fwd    = d_rd;
                end
            end
            default: ;
        endcase
    end

    // A return with nothing outstanding (and no read this cycle) is dropped.
    always_comb begin
        cnt_max  = (cnt == '1);
        spurious = mem_data_valid & ~rd_fwd & (cnt == '0);
        overflow = rd_fwd & ~mem_data_valid & cnt_max;
        cnt_nx   = cnt;
        if (rd_fwd && !mem_data_valid && !cnt_max) begin
            cnt_nx = cnt + OUT_W'(1);
        end else if (!rd_fwd && mem_data_valid && (cnt != '0)) begin
            cnt_nx = cnt - OUT_W'(1);
        end
    end

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    if (last_owner == OWN_I) begin
                        state_nx = GNT_D;
                        owner_nx = OWN_D;
                    end else begin
                        state_nx = GNT_I;
                        owner_nx = OWN_I;
                    end
                end else if (i_req) begin
                    state_nx = GNT_I;
                    owner_nx = OWN_I;
                end else if (d_req) begin
                    state_nx = GNT_D;
                    owner_nx = OWN_D;
                end
            end
            GNT_I: begin
                if (!i_req) begin
                    last_owner_nx = OWN_I;
                    state_nx      = (cnt_nx != '0) ? DRAIN : IDLE;
                end
            end
            GNT_D: begin
                if (!d_req) begin
                    last_owner_nx = OWN_D;
                    state_nx      = (cnt_nx != '0) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (cnt_nx == '0) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_owner <= OWN_I;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            cnt        <= cnt_nx;
            err        <= err | spurious | overflow;
        end
    end

    assign own_active   = (state != IDLE);
    assign i_grant      = (state == GNT_I);
    assign d_grant      = (state == GNT_D);
    assign i_data_valid = mem_data_valid & ~spurious & own_active & (owner == OWN_I);
    assign d_data_valid = mem_data_valid & ~spurious & own_active & (owner == OWN_D);
    assign rdata        = mem_rdata;
    assign err_spurious = err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fixed-latency memory model plus a scoreboard
// of expected read returns, checked with immediate assertions.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        i_req, i_rd, d_req, d_rd, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        mem_en, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, rdata;
    logic        i_grant, d_grant, i_data_valid, d_data_valid, err_spurious;

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];
    logic [16:0] sb_e;

    logic           mem_mute, inj_valid;
    logic [LAT-1:0] pv = '0;
    logic [15:0]    pa [LAT];

    mem_arbiter #(.LATENCY(LAT), .OUT_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_addr(i_addr),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .rdata(rdata), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: returns addr^0x5A5A exactly LAT cycles after a read is issued.
    always @(posedge clk) begin
        pv[0] <= mem_en & ~mem_wr & ~mem_mute;
        pa[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign mem_data_valid = pv[LAT-1] | inj_valid;
    assign mem_rdata      = pa[LAT-1] ^ 16'h5A5A;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic grants(input string tag, input logic ei, input logic ed);
        @(negedge clk);
        chk(tag, 64'({i_grant, d_grant}), 64'({ei, ed}));
    endtask

    task automatic chk_mem(input string tag, input logic en, input logic wr, input logic [15:0] a);
        chk(tag, 64'({mem_en, mem_wr, mem_addr}), 64'({en, wr, a}));
    endtask

    task automatic i_read(input logic [15:0] a);
        i_rd   = 1'b1;
        i_addr = a;
        exp_q.push_back({1'b0, a ^ 16'h5A5A});
    endtask

    // Scoreboard consumer and per-cycle grant exclusivity.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("grant_excl", 64'(i_grant & d_grant), 64'(0));
            if (i_data_valid === 1'b1 || d_data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_return", 64'({i_data_valid, d_data_valid}), 64'(0));
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("return", 64'({d_data_valid, i_data_valid, rdata}),
                        64'({sb_e[16], ~sb_e[16], sb_e[15:0]}));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; i_req = 0; i_rd = 0; i_addr = '0;
        d_req = 0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        mem_mute = 0; inj_valid = 0;
        repeat (2) adv();
        @(negedge clk);
        chk("rst_grants", 64'({i_grant, d_grant}), 64'(0));
        chk("rst_mem", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'(0));
        chk("rst_err", 64'(err_spurious), 64'(0));
        adv();
        rst = 1'b1;

        // Contention after reset goes to D; D write; next contention goes to I.
        i_req = 1; d_req = 1;
        grants("a_c0", 0, 0); adv();
        d_wr = 1; d_addr = 16'h2000; d_wdata = 16'hBEEF;
        grants("a_first_contention_d", 0, 1);
        chk("a_write_fwd", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'({2'b11, 16'h2000, 16'hBEEF}));
        adv();
        d_wr = 0; d_req = 0;
        grants("a_d_release", 0, 1); adv();
        d_req = 1;
        grants("a_idle_gap", 0, 0); adv();
        grants("a_second_contention_i", 1, 0); adv();
        i_req = 0;
        grants("a_i_release", 1, 0); adv();
        grants("a_idle_gap2", 0, 0); adv();
        d_req = 0;
        grants("a_d_single", 0, 1); adv();
        grants("a_idle", 0, 0); adv();

        // I-cache fill: 8 reads, drain, then a pending D request gets in.
        i_req = 1;
        grants("b_c0", 0, 0); adv();
        for (int k = 0; k < 8; k++) begin
            i_read(16'h0100 + 16'(2 * k));
            grants("b_fill_grant", 1, 0);
            chk_mem("b_fill_fwd", 1'b1, 1'b0, 16'h0100 + 16'(2 * k));
            adv();
        end
        i_req = 0; i_rd = 0; d_req = 1;
        grants("b_release", 1, 0);
        chk("b_release_no_en", 64'(mem_en), 64'(0));
        adv();
        for (int k = 0; k < 4; k++) begin
            grants("b_drain_idle", 0, 0);
            adv();
        end
        grants("b_d_after_drain", 0, 1);
        chk("b_sb_empty", 64'(exp_q.size()), 64'(0));
        chk("b_err_clear", 64'(err_spurious), 64'(0));
        d_req = 0;
        adv();

        // In GNT_I the D side's read strobes must be ignored.
        i_req = 1;
        grants("c_idle", 0, 0); adv();
        for (int k = 0; k < 4; k++) begin
            i_read(16'h0400 + 16'(2 * k));
            d_req = 1; d_rd = (k % 2 == 0); d_addr = 16'h3000;
            grants("c_grant_i", 1, 0);
            chk_mem("c_addr_from_i", 1'b1, 1'b0, 16'h0400 + 16'(2 * k));
            adv();
        end
        i_req = 0; i_rd = 0; d_req = 0; d_rd = 0;
        grants("c_release", 1, 0); adv();
        for (int k = 0; k < 5; k++) begin
            grants("c_drain_idle", 0, 0);
            adv();
        end
        chk("c_sb_empty", 64'(exp_q.size()), 64'(0));

        // Spurious return in IDLE: dropped, sticky error.
        inj_valid = 1;
        @(negedge clk);
        chk("d_spur_dropped", 64'({i_data_valid, d_data_valid}), 64'(0));
        chk("d_err_not_yet", 64'(err_spurious), 64'(0));
        adv();
        inj_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("d_err_sticky", 64'(err_spurious), 64'(1));
            adv();
        end

        // Reset mid-fill with 3 reads in flight.
        rst = 0; adv(); rst = 1;
        @(negedge clk);
        chk("e_err_cleared", 64'(err_spurious), 64'(0));
        adv();
        i_req = 1;
        grants("e_c0", 0, 0); adv();
        for (int k = 0; k < 3; k++) begin
            i_rd = 1; i_addr = 16'h0500 + 16'(2 * k);
            grants("e_fill", 1, 0);
            adv();
        end
        i_rd = 0;
        #3;
        rst = 0;
        #1;
        chk("e_async_grants", 64'({i_grant, d_grant}), 64'(0));
        chk("e_async_mem", 64'({mem_en, mem_wr, mem_addr, mem_wdata}), 64'(0));
        i_req = 0;
        adv();
        rst = 1;
        @(negedge clk);
        chk("e_late_return_dropped", 64'({i_data_valid, d_data_valid}), 64'(0));
        chk("e_err_before", 64'(err_spurious), 64'(0));
        adv();
        @(negedge clk);
        chk("e_err_after_late_return", 64'(err_spurious), 64'(1));
        adv();
        adv();
        adv();

        // Counter overflow with a silent memory: saturates, flags, never drains.
        rst = 0; adv(); rst = 1;
        mem_mute = 1;
        i_req = 1;
        grants("f_c0", 0, 0); adv();
        for (int k = 0; k < 8; k++) begin
            i_rd = 1; i_addr = 16'h0600 + 16'(2 * k);
            grants("f_fill", 1, 0);
            chk("f_err_pre_overflow", 64'(err_spurious), 64'(0));
            adv();
        end
        i_req = 0; i_rd = 0; d_req = 1;
        grants("f_release", 1, 0);
        chk("f_err_overflow", 64'(err_spurious), 64'(1));
        adv();
        for (int k = 0; k < 6; k++) begin
            grants("f_stuck_drain", 0, 0);
            adv();
        end
        d_req = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
